// File: rtl/e1of4_register_responder.sv
// e1of4_register_responder
// Clocked register side of the e1of4 READ / WRITE / READ+WRITE token protocol.
// Holds one 2-bit value. A 1of3 control token on Cx selects the operation.
// Writes take a 1of4 data token on Tx, and reads return a 1of4 token on Rx.
// All channels use four-phase return-to-zero handshakes with active-high enables.
//
// Parameters:
//   INIT  value loaded into the register on reset
//   DW    stored data width; must be 2 (1of4 encoding)
//
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   synchronous active-high reset
//   Cx     in   [2:0] control 1of3: bit0=READ, bit1=WRITE, bit2=READ+WRITE
//   Cxe    out  control enable (1=ready, 0=token acknowledged)
//   Tx     in   [3:0] write data 1of4
//   Txe    out  data enable
//   Rx     out  [3:0] read data 1of4
//   Rxe    in   read-channel enable from the consumer
//   ERR    out  sticky protocol-error flag, cleared only by reset
//
// Optional build macro E1OF4_REGISTER_RESPONDER_SYNC_EN:
//   Defined: Cx, Tx and Rxe each pass through a 2-flop synchronizer.
//            Every latency grows by two edges.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a control token on Cx
// SEND  | read pending, waiting for Rxe high before driving Rx
// RACK  | Rx driven, waiting for Rxe low to return Rx to neutral
// DATA  | waiting for a write token on Tx
// ACK   | drop Cxe (and Txe for writes) together on one edge
// NEUT  | waiting for the inputs to return to neutral, then re-enable
module e1of4_register_responder #(
   parameter logic [1:0] INIT = 2'b00,
   parameter int         DW   = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [2:0] Cx,
   output logic       Cxe,
   input  logic [3:0] Tx,
   output logic       Txe,
   output logic [3:0] Rx,
   input  logic       Rxe,
   output logic       ERR
);

   generate
      if (DW != 2) begin : g_dw_check
         $error("e1of4_register_responder: DW must be 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEND = 3'd1,
      RACK = 3'd2,
      DATA = 3'd3,
      ACK  = 3'd4,
      NEUT = 3'd5
   } state_t;

   logic [2:0] cx_i;
   logic [3:0] tx_i;
   logic       rxe_i;

`ifdef E1OF4_REGISTER_RESPONDER_SYNC_EN
   logic [2:0] cx_s1_q, cx_s2_q;
   logic [3:0] tx_s1_q, tx_s2_q;
   logic       rxe_s1_q, rxe_s2_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cx_s1_q  <= '0;
         cx_s2_q  <= '0;
         tx_s1_q  <= '0;
         tx_s2_q  <= '0;
         rxe_s1_q <= 1'b0;
         rxe_s2_q <= 1'b0;
      end else begin
         cx_s1_q  <= Cx;
         cx_s2_q  <= cx_s1_q;
         tx_s1_q  <= Tx;
         tx_s2_q  <= tx_s1_q;
         rxe_s1_q <= Rxe;
         rxe_s2_q <= rxe_s1_q;
      end
   end

   assign cx_i  = cx_s2_q;
   assign tx_i  = tx_s2_q;
   assign rxe_i = rxe_s2_q;
`else
   assign cx_i  = Cx;
   assign tx_i  = Tx;
   assign rxe_i = Rxe;
`endif

   function automatic logic onehot3(input logic [2:0] v);
      return (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);
   endfunction

   function automatic logic onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] index4(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   state_t     state_q, state_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic [1:0] reg_q, reg_d;
   logic [3:0] rx_q, rx_d;
   logic       cxe_q, cxe_d;
   logic       txe_q, txe_d;
   logic       err_q, err_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         reg_q   <= INIT;
         rx_q    <= '0;
         cxe_q   <= 1'b1;
         txe_q   <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         reg_q   <= reg_d;
         rx_q    <= rx_d;
         cxe_q   <= cxe_d;
         txe_q   <= txe_d;
         err_q   <= err_d;
      end
   end

   // ctrl_q[0] set means a plain READ; READ+WRITE still needs the data phase.
   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      reg_d   = reg_q;
      rx_d    = rx_q;
      cxe_d   = cxe_q;
      txe_d   = txe_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (onehot3(cx_i)) begin
               ctrl_d  = cx_i;
               state_d = cx_i[1] ? DATA : SEND;
            end else if (cx_i != 3'd0) begin
               err_d = 1'b1;
            end
         end
         SEND: begin
            if (rxe_i) begin
               rx_d    = 4'b0001 << reg_q;
               state_d = RACK;
            end
         end
         RACK: begin
            if (!rxe_i) begin
               rx_d    = 4'b0000;
               state_d = ctrl_q[0] ? ACK : DATA;
            end
         end
         DATA: begin
            if (onehot4(tx_i)) begin
               reg_d   = index4(tx_i);
               state_d = ACK;
            end else if (tx_i != 4'd0) begin
               err_d = 1'b1;
            end
         end
         ACK: begin
            // Both enables must fall together: the transmitter waits for
            // both before returning either channel to neutral.
            cxe_d = 1'b0;
            if (!ctrl_q[0]) txe_d = 1'b0;
            state_d = NEUT;
         end
         NEUT: begin
            // A Tx token left pending during a READ must not block completion.
            if ((cx_i == 3'd0) && ((tx_i == 4'd0) || ctrl_q[0])) begin
               cxe_d   = 1'b1;
               txe_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Cxe = cxe_q;
   assign Txe = txe_q;
   assign Rx  = rx_q;
   assign ERR = err_q;

endmodule
